// File: rtl/interposer_arbiter_pkg.sv
// ============================================================================
// interposer_arbiter_pkg : shared encodings, state enum and ring helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package interposer_arbiter_pkg;

  localparam logic [2:0] CTRL_SEND   = 3'b100;
  localparam logic [2:0] CTRL_RECV   = 3'b010;
  localparam logic [2:0] CTRL_BYPASS = 3'b001;
  localparam logic [2:0] CTRL_IDLE   = 3'b000;

  localparam int REQ_VALID_BIT = 3;
  localparam int REQ_DST_MSB   = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_GRANT = S_GRANT,
    ST_GUARD = S_GUARD
  } state_t;

  // Downstream ring distance from b to a, i.e. (a - b) mod n.
  function automatic logic [3:0] ring_dist(input logic [2:0] i_a,
                                           input logic [2:0] i_b,
                                           input logic [3:0] i_n);
    if (i_a >= i_b)
      return {1'b0, i_a} - {1'b0, i_b};
    else
      return {1'b0, i_a} + i_n - {1'b0, i_b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/interposer_arbiter_rr_picker.sv
// ============================================================================
// interposer_arbiter_rr_picker : combinational round-robin priority select
// Revision: 1.0
// ============================================================================
`default_nettype none

module interposer_arbiter_rr_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_valid,
  input  logic [2:0]   i_ptr,
  output logic         o_hit,
  output logic [2:0]   o_idx
);

  // Walk from farthest to nearest so the nearest requester is written last.
  always_comb begin
    logic [3:0] w_sum;
    o_hit = 1'b0;
    o_idx = 3'd0;
    w_sum = 4'd0;
    for (int d = N - 1; d >= 0; d--) begin
      w_sum = {1'b0, i_ptr} + 4'(d);
      if (w_sum >= 4'(N))
        w_sum = w_sum - 4'(N);
      if (i_valid[w_sum[2:0]]) begin
        o_hit = 1'b1;
        o_idx = w_sum[2:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/interposer_arbiter.sv
// ============================================================================
// interposer_arbiter : round-robin grant controller for the interposer ring
// Optional statistics counters enabled by INTERPOSER_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interposer_arbiter
  import interposer_arbiter_pkg::*;
#(
  parameter int NUM_NODES   = 8,
  parameter int SLOT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4*NUM_NODES-1:0]   request_in,
  output logic [3*NUM_NODES-1:0]   control_out,
  output logic                     busy,
  output logic [2:0]               grant_src,
  output logic [2:0]               grant_dst
`ifdef INTERPOSER_ARB_STATS_EN
  ,
  output logic [15:0]              grant_count,
  output logic [15:0]              drop_count
`endif
);

  localparam logic [3:0] c_num_nodes = 4'(NUM_NODES);
  localparam logic [3:0] c_slot_last = 4'(SLOT_CYCLES - 1);

  logic [NUM_NODES-1:0]   w_valid;
  logic [2:0]             w_dst_arr [NUM_NODES];
  logic                   w_hit;
  logic [2:0]             w_idx;
  logic [2:0]             w_pick_dst;
  logic [3*NUM_NODES-1:0] w_ctrl;
`ifdef INTERPOSER_ARB_STATS_EN
  logic [NUM_NODES-1:0]   w_bad;
`endif

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic [2:0]             r_ptr;
  logic [3*NUM_NODES-1:0] r_ctrl;
  logic                   r_busy;
  logic [2:0]             r_src;
  logic [2:0]             r_dst;

  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_req
    assign w_dst_arr[gi] = request_in[4*gi+REQ_DST_MSB -: 3];
    assign w_valid[gi]   = request_in[4*gi+REQ_VALID_BIT]
                           && ({1'b0, w_dst_arr[gi]} < c_num_nodes)
                           && (w_dst_arr[gi] != 3'(gi));
`ifdef INTERPOSER_ARB_STATS_EN
    assign w_bad[gi]     = request_in[4*gi+REQ_VALID_BIT] && !w_valid[gi];
`endif
  end

  interposer_arbiter_rr_picker #(
    .N (NUM_NODES)
  ) u_picker (
    .i_valid (w_valid),
    .i_ptr   (r_ptr),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  assign w_pick_dst = w_dst_arr[w_idx];

  // Nodes strictly between source and destination downstream get bypass.
  always_comb begin
    logic [3:0] w_span;
    logic [3:0] w_off;
    w_ctrl = '0;
    w_span = ring_dist(w_pick_dst, w_idx, c_num_nodes);
    w_off  = 4'd0;
    for (int k = 0; k < NUM_NODES; k++) begin
      w_off = ring_dist(3'(k), w_idx, c_num_nodes);
      if (w_off == 4'd0)
        w_ctrl[3*k +: 3] = CTRL_SEND;
      else if (w_off == w_span)
        w_ctrl[3*k +: 3] = CTRL_RECV;
      else if (w_off < w_span)
        w_ctrl[3*k +: 3] = CTRL_BYPASS;
      else
        w_ctrl[3*k +: 3] = CTRL_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ptr   <= 3'd0;
      r_ctrl  <= '0;
      r_busy  <= 1'b0;
      r_src   <= 3'd0;
      r_dst   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_ctrl  <= w_ctrl;
            r_src   <= w_idx;
            r_dst   <= w_pick_dst;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (r_cnt == c_slot_last) begin
            r_ctrl  <= '0;
            r_state <= ST_GUARD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_GUARD: begin
          r_ptr   <= ({1'b0, r_src} == c_num_nodes - 4'd1) ? 3'd0 : r_src + 3'd1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign control_out = r_ctrl;
  assign busy        = r_busy;
  assign grant_src   = r_src;
  assign grant_dst   = r_dst;

`ifdef INTERPOSER_ARB_STATS_EN
  logic [15:0] r_grant_count;
  logic [15:0] r_drop_count;

  // Grant counter wraps; drop counter saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_count <= 16'd0;
      r_drop_count  <= 16'd0;
    end else if (r_state == ST_IDLE) begin
      if (w_hit)
        r_grant_count <= r_grant_count + 16'd1;
      if ((|w_bad) && (r_drop_count != 16'hFFFF))
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign grant_count = r_grant_count;
  assign drop_count  = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_interposer_arbiter.sv
// ============================================================================
// tb_interposer_arbiter : randomized bench with ring-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interposer_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req8 = '0;
  logic [23:0] req6 = '0;
  logic [23:0] ctrl8;
  logic [17:0] ctrl6;
  logic        busy8, busy6;
  logic [2:0]  src8, dst8, src6, dst6;
`ifdef INTERPOSER_ARB_STATS_EN
  logic [15:0] gc8, dc8, gc6, dc6;
`endif

  always #5 clk = ~clk;

  interposer_arbiter #(.NUM_NODES(8), .SLOT_CYCLES(1)) u_dut8 (
    .clk         (clk),
    .reset       (rst),
    .request_in  (req8),
    .control_out (ctrl8),
    .busy        (busy8),
    .grant_src   (src8),
    .grant_dst   (dst8)
`ifdef INTERPOSER_ARB_STATS_EN
    ,
    .grant_count (gc8),
    .drop_count  (dc8)
`endif
  );

  interposer_arbiter #(.NUM_NODES(6), .SLOT_CYCLES(4)) u_dut6 (
    .clk         (clk),
    .reset       (rst),
    .request_in  (req6),
    .control_out (ctrl6),
    .busy        (busy6),
    .grant_src   (src6),
    .grant_dst   (dst6)
`ifdef INTERPOSER_ARB_STATS_EN
    ,
    .grant_count (gc6),
    .drop_count  (dc6)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, cycles left in the current slot+guard window.
  int m_left [2];
  int m_src  [2];
  int m_dst  [2];
  int m_ptr  [2];
  int m_gcnt [2];
  int m_drop [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_left[m] = 0; m_src[m] = 0; m_dst[m] = 0;
      m_ptr[m]  = 0; m_gcnt[m] = 0; m_drop[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input int n, input int slot, input logic [31:0] req);
    int  s, d;
    bit  found, bad;
    if (m_left[m] == 0) begin
      found = 0;
      bad   = 0;
      for (int k = 0; k < n; k++) begin
        s = (m_ptr[m] + k) % n;
        d = int'(req[4*s +: 3]);
        if (req[4*s+3]) begin
          if (d >= n || d == s) bad = 1;
          else if (!found) begin
            found    = 1;
            m_src[m] = s;
            m_dst[m] = d;
          end
        end
      end
      if (bad && m_drop[m] < 65535) m_drop[m]++;
      if (found) begin
        m_left[m] = slot + 1;
        m_gcnt[m] = (m_gcnt[m] + 1) % 65536;
      end
    end else begin
      m_left[m]--;
      if (m_left[m] == 0) m_ptr[m] = (m_src[m] + 1) % n;
    end
  endtask

  function automatic logic [31:0] ring_ctrl(input int n, input int s, input int d);
    logic [31:0] v;
    int k;
    v = '0;
    v[3*s +: 3] = 3'b100;
    k = (s + 1) % n;
    for (int step = 0; step < n; step++) begin
      if (k == d) break;
      v[3*k +: 3] = 3'b001;
      k = (k + 1) % n;
    end
    v[3*d +: 3] = 3'b010;
    return v;
  endfunction

  task automatic check_all();
    check_val("busy8", 32'(busy8), 32'(m_left[0] > 0));
    check_val("ctrl8", 32'(ctrl8), (m_left[0] > 1) ? ring_ctrl(8, m_src[0], m_dst[0]) : 32'd0);
    check_val("src8",  32'(src8),  32'(m_src[0]));
    check_val("dst8",  32'(dst8),  32'(m_dst[0]));
    check_val("busy6", 32'(busy6), 32'(m_left[1] > 0));
    check_val("ctrl6", 32'(ctrl6), (m_left[1] > 1) ? ring_ctrl(6, m_src[1], m_dst[1]) : 32'd0);
    check_val("src6",  32'(src6),  32'(m_src[1]));
    check_val("dst6",  32'(dst6),  32'(m_dst[1]));
`ifdef INTERPOSER_ARB_STATS_EN
    check_val("gcnt8", 32'(gc8), 32'(m_gcnt[0]));
    check_val("drop8", 32'(dc8), 32'(m_drop[0]));
    check_val("gcnt6", 32'(gc6), 32'(m_gcnt[1]));
    check_val("drop6", 32'(dc6), 32'(m_drop[1]));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0, 8, 1, req8);
      model_step(1, 6, 4, {8'h0, req6});
    end
    #1;
    check_all();
  endtask

  int          g_src [$];
  int          g_cyc [$];
  logic [23:0] prev;

  initial begin
    model_reset();
    repeat (2) cycle();
    check_val("rst_ctrl8", 32'(ctrl8), 32'd0);
    rst = 1'b0;

    // Node 4 -> node 5, adjacent.
    req8 = 32'hD << 16;
    cycle();
    check_val("t1_ctrl", 32'(ctrl8), 32'h0001_4000);
    check_val("t1_src",  32'(src8),  32'd4);
    req8 = '0;
    cycle();
    check_val("t1_guard", 32'(ctrl8), 32'd0);
    cycle();

    // Node 6 -> node 1, wrapping through 7 and 0.
    req8 = 32'h9 << 24;
    cycle();
    check_val("t2_ctrl", 32'(ctrl8), 32'h0030_0011);
    req8 = '0;
    repeat (2) cycle();

    // Nodes 2 and 5 contending from rr_ptr = 0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req8 = (32'hB << 8) | (32'hE << 20);
    prev = '0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (ctrl8 != 0 && prev == 0) begin
        g_src.push_back(int'(src8));
        g_cyc.push_back(c);
      end
      prev = ctrl8;
    end
    check_val("t3_ngrants", 32'(g_src.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_src.size()) check_val("t3_src", 32'(g_src[i]), (i % 2 == 1) ? 32'd5 : 32'd2);
      if (i > 0 && i < g_cyc.size()) check_val("t3_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end
    req8 = '0;

    // N = 6: node 3 -> 3 and node 1 -> 7 are both invalid.
    req6 = (24'hB << 12) | (24'hF << 4);
    repeat (6) cycle();
    check_val("t4_busy6", 32'(busy6), 32'd0);
    req6 = '0;

    // Advance rr_ptr, then reset in the 2nd GRANT cycle of a SLOT_CYCLES = 4 grant.
    req6 = 24'h9 << 16;
    cycle();
    req6 = '0;
    repeat (6) cycle();
    req6 = 24'hC << 8;
    cycle();
    cycle();
    check_val("t5_busy_pre", 32'(busy6), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_ctrl_async", 32'(ctrl6), 32'd0);
    check_val("t5_busy_async", 32'(busy6), 32'd0);
    cycle();
    rst = 1'b0;
    req6 = (24'hC << 12) | (24'h9 << 20);
    cycle();
    check_val("t5_src", 32'(src6), 32'd3);
    req6 = '0;
    repeat (6) cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 8; k++)
        if ($urandom_range(3) == 0)
          req8[4*k +: 4] = ($urandom_range(9) < 7) ? {1'b1, 3'($urandom_range(7))} : 4'h0;
      for (int k = 0; k < 6; k++)
        if ($urandom_range(3) == 0)
          req6[4*k +: 4] = ($urandom_range(9) < 7) ? {1'b1, 3'($urandom_range(7))} : 4'h0;
      rst = ($urandom_range(199) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
